// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges N client memory interfaces onto one memory port.
// Commands are serialised, the write-data channel stays locked to the granted
// client for a whole burst, and the client index is prepended to the memory
// tag so responses can be routed back combinationally.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority (lowest index wins) with no rotation pointer.
module mem_port_arbiter #(
  parameter int unsigned N_CLIENTS  = 2,
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned TAG_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned DATA_BEATS = 4,
  localparam int unsigned IDX_WIDTH = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_CLIENTS-1:0]              c_cmd_valid,
  output logic [N_CLIENTS-1:0]              c_cmd_ready,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0]   c_cmd_addr,
  input  logic [N_CLIENTS*TAG_WIDTH-1:0]    c_cmd_tag,
  input  logic [N_CLIENTS-1:0]              c_cmd_rw,
  input  logic [N_CLIENTS-1:0]              c_data_valid,
  output logic [N_CLIENTS-1:0]              c_data_ready,
  input  logic [N_CLIENTS*DATA_WIDTH-1:0]   c_data_data,
  output logic [N_CLIENTS-1:0]              c_resp_valid,
  output logic [DATA_WIDTH-1:0]             c_resp_data,
  output logic [TAG_WIDTH-1:0]              c_resp_tag,
  output logic                              mem_cmd_valid,
  input  logic                              mem_cmd_ready,
  output logic [ADDR_WIDTH-1:0]             mem_cmd_addr,
  output logic [TAG_WIDTH+IDX_WIDTH-1:0]    mem_cmd_tag,
  output logic                              mem_cmd_rw,
  output logic                              mem_data_valid,
  input  logic                              mem_data_ready,
  output logic [DATA_WIDTH-1:0]             mem_data_data,
  input  logic                              mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]             mem_resp_data,
  input  logic [TAG_WIDTH+IDX_WIDTH-1:0]    mem_resp_tag,
  output logic                              resp_err
);

  localparam int unsigned CNT_WIDTH = $clog2(DATA_BEATS) + 1;

  typedef enum logic [1:0] {IDLE, CMD, WDATA} state_t;

  state_t                 state, state_nxt;
  logic [IDX_WIDTH-1:0]   grant, grant_nxt;
  logic [CNT_WIDTH-1:0]   beat_cnt, beat_cnt_nxt;
  logic [IDX_WIDTH-1:0]   pick;
  logic                   any_req;
  logic [IDX_WIDTH-1:0]   resp_idx;
  logic                   resp_idx_ok;

`ifdef MEM_ARB_RR_EN
  logic [IDX_WIDTH-1:0]   rr_ptr;
  int unsigned            cand;

  // Round-robin pick: first requester at or after rr_ptr, wrapping.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < N_CLIENTS; k++) begin
      cand = (32'(rr_ptr) + k) % N_CLIENTS;
      if (!any_req && c_cmd_valid[cand]) begin
        pick    = IDX_WIDTH'(cand);
        any_req = 1'b1;
      end
    end
  end

  // Rotation pointer advances past the client whose command was accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (state == CMD && mem_cmd_ready) begin
      rr_ptr <= (32'(grant) == N_CLIENTS - 1) ? '0 : grant + IDX_WIDTH'(1);
    end
  end
`else
  // Fixed-priority pick: lowest requesting index wins.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    for (int unsigned k = 0; k < N_CLIENTS; k++) begin
      if (!any_req && c_cmd_valid[k]) begin
        pick    = IDX_WIDTH'(k);
        any_req = 1'b1;
      end
    end
  end
`endif

  // State, grant and beat counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Next-state logic and per-client handshake steering.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    beat_cnt_nxt   = beat_cnt;
    c_cmd_ready    = '0;
    c_data_ready   = '0;
    mem_cmd_valid  = 1'b0;
    mem_data_valid = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_nxt = pick;
          state_nxt = CMD;
        end
      end
      CMD: begin
        mem_cmd_valid      = 1'b1;
        c_cmd_ready[grant] = mem_cmd_ready;
        if (mem_cmd_ready) begin
          if (c_cmd_rw[grant]) begin
            state_nxt    = WDATA;
            beat_cnt_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      WDATA: begin
        mem_data_valid      = c_data_valid[grant];
        c_data_ready[grant] = mem_data_ready;
        if (c_data_valid[grant] && mem_data_ready) begin
          beat_cnt_nxt = beat_cnt + CNT_WIDTH'(1);
          if (beat_cnt == CNT_WIDTH'(DATA_BEATS - 1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_cmd_addr  = c_cmd_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
  assign mem_cmd_tag   = {grant, c_cmd_tag[grant*TAG_WIDTH +: TAG_WIDTH]};
  assign mem_cmd_rw    = c_cmd_rw[grant];
  assign mem_data_data = c_data_data[grant*DATA_WIDTH +: DATA_WIDTH];

  assign resp_idx    = mem_resp_tag[TAG_WIDTH +: IDX_WIDTH];
  assign resp_idx_ok = (32'(resp_idx) < N_CLIENTS);
  assign c_resp_data = mem_resp_data;
  assign c_resp_tag  = mem_resp_tag[TAG_WIDTH-1:0];

  // Response strobe routed by the index field; unknown indices are dropped.
  always_comb begin
    c_resp_valid = '0;
    if (resp_idx_ok) c_resp_valid[resp_idx] = mem_resp_valid;
  end

  // Sticky flag for responses carrying an index with no matching client.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_err <= 1'b0;
    end else if (mem_resp_valid && !resp_idx_ok) begin
      resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (3 clients, 4-beat bursts).
module tb_mem_port_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 8;
  localparam int unsigned TW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned DB = 4;
  localparam int unsigned IW = 2;

  logic              clk;
  logic              reset;
  logic [N-1:0]      c_cmd_valid, c_cmd_ready, c_cmd_rw;
  logic [N*AW-1:0]   c_cmd_addr;
  logic [N*TW-1:0]   c_cmd_tag;
  logic [N-1:0]      c_data_valid, c_data_ready;
  logic [N*DW-1:0]   c_data_data;
  logic [N-1:0]      c_resp_valid;
  logic [DW-1:0]     c_resp_data;
  logic [TW-1:0]     c_resp_tag;
  logic              mem_cmd_valid, mem_cmd_ready, mem_cmd_rw;
  logic [AW-1:0]     mem_cmd_addr;
  logic [TW+IW-1:0]  mem_cmd_tag;
  logic              mem_data_valid, mem_data_ready;
  logic [DW-1:0]     mem_data_data;
  logic              mem_resp_valid;
  logic [DW-1:0]     mem_resp_data;
  logic [TW+IW-1:0]  mem_resp_tag;
  logic              resp_err;

  int passed = 0;
  int total  = 0;
  int beats  = 0;
  logic [5:0] exp_tag;

  mem_port_arbiter #(
    .N_CLIENTS(N), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .DATA_BEATS(DB)
  ) dut (
    .clk(clk), .reset(reset),
    .c_cmd_valid(c_cmd_valid), .c_cmd_ready(c_cmd_ready), .c_cmd_addr(c_cmd_addr),
    .c_cmd_tag(c_cmd_tag), .c_cmd_rw(c_cmd_rw),
    .c_data_valid(c_data_valid), .c_data_ready(c_data_ready), .c_data_data(c_data_data),
    .c_resp_valid(c_resp_valid), .c_resp_data(c_resp_data), .c_resp_tag(c_resp_tag),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_tag(mem_cmd_tag), .mem_cmd_rw(mem_cmd_rw),
    .mem_data_valid(mem_data_valid), .mem_data_ready(mem_data_ready), .mem_data_data(mem_data_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag),
    .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1;
    c_cmd_valid = '0; c_cmd_rw = '0; c_data_valid = '0;
    c_cmd_addr = {8'h32, 8'h21, 8'h10};
    c_cmd_tag  = {4'h7, 4'h5, 4'h3};
    c_data_data = '0;
    mem_cmd_ready = 1'b0; mem_data_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_tag = '0;
    step(); step();
    chk("rst_cmd_ready", 32'(c_cmd_ready), 0);
    chk("rst_data_ready", 32'(c_data_ready), 0);
    chk("rst_mem_cmd_valid", 32'(mem_cmd_valid), 0);
    chk("rst_mem_data_valid", 32'(mem_data_valid), 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_resp_valid", 32'(c_resp_valid), 0);
    reset = 1'b0;

    // Two clients read simultaneously and keep requesting.
    c_cmd_valid = 3'b011;
    mem_cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
`ifdef MEM_ARB_RR_EN
      exp_tag = (i % 2 == 0) ? 6'h03 : 6'h15;
`else
      exp_tag = 6'h03;
`endif
      chk("arb_cmd_valid", 32'(mem_cmd_valid), 1);
      chk("arb_cmd_tag", 32'(mem_cmd_tag), 32'(exp_tag));
      chk("arb_cmd_addr", 32'(mem_cmd_addr), (exp_tag == 6'h03) ? 32'h10 : 32'h21);
      chk("arb_cmd_ready", 32'(c_cmd_ready), (exp_tag == 6'h03) ? 32'h1 : 32'h2);
      step();
      chk("arb_idle_gap", 32'(mem_cmd_valid), 0);
    end
    c_cmd_valid = '0;

    // Client 1 write burst, memory data ready toggling, client 0 read pending.
    c_cmd_valid = 3'b010; c_cmd_rw = 3'b010;
    c_data_valid = 3'b011;
    c_data_data[0 +: DW]  = 16'hDEAD;
    c_data_data[DW +: DW] = 16'hB000;
    step();
    chk("wr_cmd_tag", 32'(mem_cmd_tag), 32'h15);
    chk("wr_cmd_rw", 32'(mem_cmd_rw), 1);
    c_cmd_valid = 3'b011;
    step();
    c_cmd_valid = 3'b001; c_cmd_rw = 3'b000;
    beats = 0;
    for (int c = 0; c < 8; c++) begin
      mem_data_ready = (c % 2 == 1);
      c_data_data[DW +: DW] = 16'hB000 + 16'(beats);
      #1;
      chk("wr_data_valid", 32'(mem_data_valid), 1);
      chk("wr_data_data", 32'(mem_data_data), 32'hB000 + 32'(beats));
      chk("wr_data_ready", 32'(c_data_ready), mem_data_ready ? 32'h2 : 32'h0);
      chk("wr_no_cmd", 32'(mem_cmd_valid), 0);
      if (mem_data_ready) beats++;
      step();
    end
    chk("wr_done_data_valid", 32'(mem_data_valid), 0);
    chk("wr_done_no_cmd_yet", 32'(mem_cmd_valid), 0);
    mem_data_ready = 1'b0;
    step();
    chk("pend_cmd_valid", 32'(mem_cmd_valid), 1);
    chk("pend_cmd_tag", 32'(mem_cmd_tag), 32'h03);
    chk("pend_cmd_rw", 32'(mem_cmd_rw), 0);
    step();
    c_cmd_valid = '0;
    c_data_valid = '0;

    // Memory stalls the command; grant must not move.
    mem_cmd_ready = 1'b0;
    c_cmd_valid = 3'b010;
    step();
    c_cmd_valid = 3'b011;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_cmd_valid", 32'(mem_cmd_valid), 1);
      chk("stall_cmd_tag", 32'(mem_cmd_tag), 32'h15);
      chk("stall_cmd_addr", 32'(mem_cmd_addr), 32'h21);
      chk("stall_cmd_ready", 32'(c_cmd_ready), 0);
    end
    mem_cmd_ready = 1'b1;
    #1;
    chk("stall_release_ready", 32'(c_cmd_ready), 32'h2);
    step();
    c_cmd_valid = 3'b001;
    step();
    chk("stall_next_tag", 32'(mem_cmd_tag), 32'h03);
    step();
    c_cmd_valid = '0;

    // Response routing and sticky error.
    mem_resp_valid = 1'b1; mem_resp_tag = {2'd2, 4'hA}; mem_resp_data = 16'hCAFE;
    #1;
    chk("resp_idx2_valid", 32'(c_resp_valid), 32'h4);
    chk("resp_idx2_tag", 32'(c_resp_tag), 32'hA);
    chk("resp_idx2_data", 32'(c_resp_data), 32'hCAFE);
    mem_resp_tag = {2'd0, 4'h6};
    #1;
    chk("resp_idx0_valid", 32'(c_resp_valid), 32'h1);
    mem_resp_valid = 1'b0; mem_resp_tag = {2'd1, 4'h2};
    #1;
    chk("resp_novalid", 32'(c_resp_valid), 0);
    step();
    chk("resp_err_clean", 32'(resp_err), 0);
    mem_resp_valid = 1'b1; mem_resp_tag = {2'd3, 4'h1};
    #1;
    chk("resp_idx3_valid", 32'(c_resp_valid), 0);
    step();
    chk("resp_err_set", 32'(resp_err), 1);
    mem_resp_tag = {2'd1, 4'h2};
    #1;
    chk("resp_idx1_valid", 32'(c_resp_valid), 32'h2);
    mem_resp_valid = 1'b0;
    step(); step();
    chk("resp_err_sticky", 32'(resp_err), 1);

    // Reset in the middle of a burst, then a complete burst.
    c_cmd_valid = 3'b001; c_cmd_rw = 3'b001; c_data_valid = 3'b001;
    mem_data_ready = 1'b1;
    step();
    step();
    c_cmd_valid = '0;
    for (int b = 0; b < 3; b++) begin
      c_data_data[0 +: DW] = 16'hA000 + 16'(b);
      #1;
      chk("pre_rst_data", 32'(mem_data_data), 32'hA000 + 32'(b));
      step();
    end
    reset = 1'b1;
    #1;
    chk("mid_rst_data_valid", 32'(mem_data_valid), 0);
    chk("mid_rst_data_ready", 32'(c_data_ready), 0);
    chk("mid_rst_cmd_ready", 32'(c_cmd_ready), 0);
    chk("mid_rst_cmd_valid", 32'(mem_cmd_valid), 0);
    chk("mid_rst_resp_err", 32'(resp_err), 0);
    step();
    reset = 1'b0;
    c_cmd_valid = 3'b001;
    step();
    chk("post_rst_tag", 32'(mem_cmd_tag), 32'h03);
    chk("post_rst_rw", 32'(mem_cmd_rw), 1);
    step();
    c_cmd_valid = '0;
    for (int b = 0; b < 4; b++) begin
      c_data_data[0 +: DW] = 16'hA010 + 16'(b);
      #1;
      chk("post_rst_data_valid", 32'(mem_data_valid), 1);
      chk("post_rst_data", 32'(mem_data_data), 32'hA010 + 32'(b));
      step();
    end
    chk("post_rst_burst_end", 32'(mem_data_valid), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
